// File: rtl/rsp_serializer.sv
// Buffers command responses in a small FIFO and streams each one to the UART
// transmitter as a SYNC/type/addr/data[/checksum] byte frame over valid/ready.
module rsp_serializer #(
   parameter int         FIFO_DEPTH  = 4,
   parameter logic [7:0] SYNC_BYTE   = 8'hA5,
   parameter bit         CHECKSUM_EN = 1'b1
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [17:0]                 rsp_pkt,
   input  logic                        rsp_valid,
   output logic [7:0]                  tx_data,
   output logic                        tx_valid,
   input  logic                        tx_ready,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count,
   output logic                        overflow,
   output logic                        idle
);

   localparam int         PW   = $clog2(FIFO_DEPTH);
   localparam int         CW   = PW + 1;
   localparam logic [2:0] LAST = CHECKSUM_EN ? 3'd4 : 3'd3;

   typedef enum logic {S_IDLE, S_SEND} state_t;

   state_t        state, state_nxt;
   logic [17:0]   mem [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [17:0]   shadow;
   logic [7:0]    csum;
   logic [2:0]    byte_idx;
   logic          full, empty, push, pop, accept;

   // Packet layout: {cmd_type[1:0], addr[7:0], data[7:0]}
   function automatic logic [7:0] checksum(input logic [17:0] p);
      return {6'b0, p[17:16]} ^ p[15:8] ^ p[7:0];
   endfunction

   function automatic logic [7:0] frame_byte(input logic [2:0] idx, input logic [17:0] p,
                                             input logic [7:0] c);
      logic [7:0] b;
      case (idx)
         3'd0:    b = SYNC_BYTE;
         3'd1:    b = {6'b0, p[17:16]};
         3'd2:    b = p[15:8];
         3'd3:    b = p[7:0];
         default: b = c;
      endcase
      return b;
   endfunction

   assign empty    = (fifo_count == '0);
   assign full     = (fifo_count == CW'(FIFO_DEPTH));
   // A pop in the same cycle frees a slot, so a push into a full FIFO still succeeds.
   assign push     = rsp_valid && (!full || pop);
   assign tx_valid = (state == S_SEND);
   assign idle     = empty && (state == S_IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      accept    = 1'b0;
      case (state)
         S_IDLE: begin
            if (!empty) begin
               pop       = 1'b1;
               state_nxt = S_SEND;
            end
         end
         S_SEND: begin
            accept = tx_ready;
            if (tx_ready && (byte_idx == LAST)) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
         overflow   <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + CW'(1);
            2'b01:   fifo_count <= fifo_count - CW'(1);
            default: fifo_count <= fifo_count;
         endcase
         if (rsp_valid && full && !pop) overflow <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= rsp_pkt;
   end

   // Frame bytes come from the shadow copy so later pushes cannot disturb a frame in flight.
   always_ff @(posedge clk) begin
      if (pop) begin
         shadow <= mem[rd_ptr];
         csum   <= checksum(mem[rd_ptr]);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         byte_idx <= '0;
         tx_data  <= '0;
      end else if (pop) begin
         byte_idx <= '0;
         tx_data  <= SYNC_BYTE;
      end else if (accept && (byte_idx != LAST)) begin
         byte_idx <= byte_idx + 3'd1;
         tx_data  <= frame_byte(byte_idx + 3'd1, shadow, csum);
      end
   end

endmodule
